// File: rtl/wfifo_write_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the write arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus FIFO.
interface wfifo_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  modport master (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );

  modport slave (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );
endinterface

// File: rtl/wfifo_write_arbiter.sv
// Burst-level round-robin arbiter sharing one async-FIFO write port among NREQ
// requesters, with a per-grant beat cap and combinational wfull gating.
//
// state | meaning
// IDLE  | no writes; pick the first valid requester at or after rr_ptr
// BURST | stream beats from grant_id until last beat or beat cap
module wfifo_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 8
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  wfifo_write_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

  logic           win_found;
  logic [IDW-1:0] winner;
  logic           beat_acc;
  logic           burst_end;

  logic [NREQ-1:0]  ready_w;
  logic             winc_w;
  logic [DSIZE-1:0] wdata_w;
  logic             busy_w;

  // Cyclic scan from rr_ptr; wrap by subtraction so non-power-of-2 NREQ stays in range.
  always_comb begin
    win_found = 1'b0;
    winner    = rr_ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      int s;
      s = int'(rr_ptr_q) + i;
      if (s >= NREQ) s = s - NREQ;
      if (!win_found && bus.req_valid[s]) begin
        win_found = 1'b1;
        winner    = IDW'(s);
      end
    end
  end

  assign beat_acc  = (state_q == BURST) && bus.req_valid[grant_q] && !bus.wfull;
  assign burst_end = bus.req_last[grant_q] || (beat_cnt_q == CW'(MAXBURST - 1));

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d    = winner;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (beat_acc) begin
          if (burst_end) begin
            state_d    = IDLE;
            rr_ptr_d   = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data mux keyed by the registered grant so wdata never follows request churn.
  always_comb begin
    ready_w = '0;
    winc_w  = 1'b0;
    wdata_w = '0;
    busy_w  = 1'b0;
    if (state_q == BURST) begin
      busy_w           = 1'b1;
      ready_w[grant_q] = !bus.wfull;
      winc_w           = beat_acc;
      wdata_w          = bus.req_data[grant_q*DSIZE +: DSIZE];
    end
  end

  assign bus.req_ready = ready_w;
  assign bus.winc      = winc_w;
  assign bus.wdata     = wdata_w;
  assign bus.busy      = busy_w;
  assign bus.grant_id  = grant_q;
endmodule
